vga_rx_decoder: RTL and testbench
=================================

// Module: vga_rx_decoder
// PURPOSE
//  Receive side of our VGA timing interface. Samples hs/vs/rgb produced by the VGA timing generator (or an external source on the same clk).
//  Recovers pixel coordinates, checks 640x480@60 timing, and emits one (x, y, data) strobe per active pixel once locked.
//  Used for loopback self-test of the display path and as a frame-capture front end feeding a framebuffer writer.
// PARAMETERS
//  HS_TOTAL    800  samples per line
//  HS_LEFT     144  samples from hs rise to first active pixel (sync + back porch)
//  H_ACTIVE    640  active pixels per line
//  VS_TOTAL    525  lines per frame
//  VS_TOP      35   lines from vs rise to first active line
//  V_ACTIVE    480  active lines per frame
//  LOCK_FRAMES 2    consecutive correct frames needed to assert locked
// PORTS
//  clk        in   1   pixel clock, same clock as the source (25.175 MHz)
//  rstn       in   1   reset; asynchronous, active-low
//  hs         in   1   horizontal sync, active-high
//  vs         in   1   vertical sync, active-high
//  rgb        in   12  pixel colour {R4,G4,B4}
//  pix_x      out  10  recovered column 0..639; 10'h3FF when pix_valid=0
//  pix_y      out  10  recovered row 0..479; 10'h3FF when pix_valid=0
//  pix_data   out  12  sampled rgb; 12'h000 when pix_valid=0
//  pix_valid  out  1   one strobe per active pixel, only while locked
//  frame_start out 1   1-cycle pulse coincident with valid pixel (0,0)
//  locked     out  1   timing verified for LOCK_FRAMES frames
//  err        out  1   1-cycle pulse on any timing violation
// BEHAVIOUR
//  - Reset: pix_x=pix_y=10'h3FF, pix_data=0, pix_valid=0, frame_start=0, locked=0, err=0. All counters and history cleared.
//  - Inputs registered twice (s1, s2). hs_rise = s1.hs & ~s2.hs; vs_rise likewise.
//  - h counter (10b): set to 0 on hs_rise, else +1, saturating at 1023. v counter (10b): set to 0 on vs_rise, else +1 on hs_rise, saturating at 1023.
//  - Active window: h in [HS_LEFT, HS_LEFT+H_ACTIVE) and v in [VS_TOP, VS_TOP+V_ACTIVE).
//    Then x = h-HS_LEFT and y = v-VS_TOP.
//  - Outputs registered. A pixel driven on hs/vs/rgb at cycle t appears on pix_* at cycle t+3. Latency is fixed.
//  - Line check: at each hs_rise after the first one since reset/unlock, measured length (h+1) must equal HS_TOTAL.
//  - Frame check: at each vs_rise after the first, lines (v+1) must equal VS_TOTAL.
//  - vs_rise must coincide with hs_rise. A vs_rise without it is a violation; v is still set to 0.
//  - Timeout: h reaching 1023 (no hs) is a violation.
//  - Lock FSM, states HUNT -> CHECK -> LOCKED:
//    - HUNT: wait for the first vs_rise, then go to CHECK with good=0.
//    - CHECK: each vs_rise closing a frame with no violation does good+1; at good==LOCK_FRAMES go to LOCKED and set locked=1 on that cycle.
//    - LOCKED: pixels of the frame just starting are output.
//    - Any violation in CHECK or LOCKED: err pulse, locked=0, good=0, state HUNT. The vs_rise that caused or revealed it counts as HUNT's first vs_rise.
//  - pix_valid is asserted only in LOCKED and inside the active window. An error mid-frame stops pix_valid on the next output cycle.
//  - rgb outside the active window is ignored.
//  - No back-pressure: the consumer must accept one pixel per clk.
// TESTING
//  - T1: reset, then feed from the VGA timing generator with pixel={x[3:0],y[3:0],4'hA}.
//    Required: locked rises at the 3rd vs_rise + 3 clk, then exactly 307200 pix_valid per frame.
//    frame_start occurs once per frame, at pix_x=0, pix_y=0.
//  - T2: continue T1. Required: every strobe has pix_data=={pix_x[3:0],pix_y[3:0],4'hA}, and x/y are raster-ordered with no gaps.
//  - T3: while locked, shorten one line to 799 clk. Required: err pulse at the following hs_rise, locked=0, and pix_valid stays 0 for the rest of that frame.
//    Relock follows after 2 good frames.
//  - T4: hold hs low while locked. Required: err 1 pulse when h saturates at 1023 (~1024 clk after the last hs_rise), then locked=0.
//  - T5: inject a vs rise at hcnt=400. Required: err pulse, locked=0, y restarts from 0.
//  - T6: assert rstn=0 mid-active-line. Required: all outputs at reset values asynchronously, then relock per T1 timing after release.

Source files
------------

// File: rtl/vga_rx_decoder_if.sv
// Video-in / pixel-out bundle between a VGA timing source and vga_rx_decoder.
interface vga_rx_decoder_if;
   logic        hs;
   logic        vs;
   logic [11:0] rgb;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [11:0] pix_data;
   logic        pix_valid;
   logic        frame_start;
   logic        locked;
   logic        err;

   modport master (
      output hs, vs, rgb,
      input  pix_x, pix_y, pix_data, pix_valid, frame_start, locked, err
   );

   modport slave (
      input  hs, vs, rgb,
      output pix_x, pix_y, pix_data, pix_valid, frame_start, locked, err
   );
endinterface

// File: rtl/vga_rx_decoder.sv
// VGA receive decoder: recovers pixel coordinates from hs/vs, verifies line and
// frame timing, and forwards active pixels once the timing has been stable long enough.
module vga_rx_decoder #(
   parameter int unsigned HS_TOTAL    = 800,
   parameter int unsigned HS_LEFT     = 144,
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned VS_TOTAL    = 525,
   parameter int unsigned VS_TOP      = 35,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input logic             clk,
   input logic             rstn,
   vga_rx_decoder_if.slave vif
);
   localparam logic [9:0] H_LO    = 10'(HS_LEFT);
   localparam logic [9:0] H_HI    = 10'(HS_LEFT + H_ACTIVE);
   localparam logic [9:0] V_LO    = 10'(VS_TOP);
   localparam logic [9:0] V_HI    = 10'(VS_TOP + V_ACTIVE);
   localparam logic [9:0] H_LAST  = 10'(HS_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(VS_TOTAL - 1);
   localparam logic [9:0] CNT_MAX = '1;
   localparam logic [9:0] TMO_PRE = 10'h3FE;
   localparam int unsigned GW     = $clog2(LOCK_FRAMES + 1);
   localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

   typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_e;

   state_e          state_q, state_d;
   logic [GW-1:0]   good_q, good_d;
   logic            hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
   logic            vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
   logic [11:0]     rgb_s1_q, rgb_s1_d, rgb_s2_q, rgb_s2_d;
   logic [9:0]      h_q, h_d, v_q, v_d;
   logic            line_seen_q, line_seen_d;
   logic            fault_q, fault_d;
   logic [9:0]      pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [11:0]     pix_data_q, pix_data_d;
   logic            pix_valid_q, pix_valid_d;
   logic            frame_start_q, frame_start_d;
   logic            locked_q, locked_d;
   logic            err_q, err_d;

   logic hs_rise, vs_rise, line_bad, frame_bad, sync_bad, timeout, active;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= HUNT;
         good_q        <= '0;
         hs_s1_q       <= 1'b0;
         hs_s2_q       <= 1'b0;
         vs_s1_q       <= 1'b0;
         vs_s2_q       <= 1'b0;
         rgb_s1_q      <= '0;
         rgb_s2_q      <= '0;
         h_q           <= '0;
         v_q           <= '0;
         line_seen_q   <= 1'b0;
         fault_q       <= 1'b0;
         pix_x_q       <= '1;
         pix_y_q       <= '1;
         pix_data_q    <= '0;
         pix_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         good_q        <= good_d;
         hs_s1_q       <= hs_s1_d;
         hs_s2_q       <= hs_s2_d;
         vs_s1_q       <= vs_s1_d;
         vs_s2_q       <= vs_s2_d;
         rgb_s1_q      <= rgb_s1_d;
         rgb_s2_q      <= rgb_s2_d;
         h_q           <= h_d;
         v_q           <= v_d;
         line_seen_q   <= line_seen_d;
         fault_q       <= fault_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_data_q    <= pix_data_d;
         pix_valid_q   <= pix_valid_d;
         frame_start_q <= frame_start_d;
         locked_q      <= locked_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      hs_s1_d  = vif.hs;
      vs_s1_d  = vif.vs;
      rgb_s1_d = vif.rgb;
      hs_s2_d  = hs_s1_q;
      vs_s2_d  = vs_s1_q;
      rgb_s2_d = rgb_s1_q;

      hs_rise = hs_s1_q & ~hs_s2_q;
      vs_rise = vs_s1_q & ~vs_s2_q;

      // h/v update on the rise edge so that h_q/v_q describe the sample held in s2
      h_d = hs_rise ? '0 : ((h_q == CNT_MAX) ? h_q : h_q + 10'd1);
      if (vs_rise)
         v_d = '0;
      else if (hs_rise && (v_q != CNT_MAX))
         v_d = v_q + 10'd1;
      else
         v_d = v_q;

      line_bad  = hs_rise && line_seen_q && (h_q != H_LAST);
      frame_bad = vs_rise && (v_q != V_LAST);
      sync_bad  = vs_rise && !hs_rise;
      timeout   = !hs_rise && (h_q == TMO_PRE);
      fault_d   = (state_q != HUNT) && (line_bad || frame_bad || sync_bad || timeout);

      line_seen_d = fault_d ? 1'b0 : (hs_rise ? 1'b1 : line_seen_q);

      state_d = state_q;
      good_d  = good_q;
      case (state_q)
         HUNT: begin
            if (vs_rise) begin
               state_d = CHECK;
               good_d  = '0;
            end
         end
         CHECK, LOCKED: begin
            if (fault_d) begin
               // a faulting vs_rise doubles as the first vs_rise of the new hunt
               good_d  = '0;
               state_d = vs_rise ? CHECK : HUNT;
            end else if (vs_rise && (state_q == CHECK)) begin
               good_d = good_q + 1'b1;
               if (good_q + 1'b1 == GOOD_LOCK)
                  state_d = LOCKED;
            end
         end
         default: begin
            state_d = HUNT;
            good_d  = '0;
         end
      endcase

      active        = (h_q >= H_LO) && (h_q < H_HI) && (v_q >= V_LO) && (v_q < V_HI);
      pix_valid_d   = (state_q == LOCKED) && active;
      pix_x_d       = pix_valid_d ? h_q - H_LO : '1;
      pix_y_d       = pix_valid_d ? v_q - V_LO : '1;
      pix_data_d    = pix_valid_d ? rgb_s2_q : '0;
      frame_start_d = pix_valid_d && (h_q == H_LO) && (v_q == V_LO);
      locked_d      = (state_q == LOCKED);
      err_d         = fault_q;
   end

   assign vif.pix_x       = pix_x_q;
   assign vif.pix_y       = pix_y_q;
   assign vif.pix_data    = pix_data_q;
   assign vif.pix_valid   = pix_valid_q;
   assign vif.frame_start = frame_start_q;
   assign vif.locked      = locked_q;
   assign vif.err         = err_q;
endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder using a shrunken raster (20x10 samples, 10x4 active).
module tb_vga_rx_decoder;
   localparam int HT = 20, HL = 6, HA = 10, VT = 10, VTOP = 3, VA = 4;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   vga_rx_decoder_if vif ();

   vga_rx_decoder #(
      .HS_TOTAL(HT), .HS_LEFT(HL), .H_ACTIVE(HA),
      .VS_TOTAL(VT), .VS_TOP(VTOP), .V_ACTIVE(VA), .LOCK_FRAMES(2)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .vif(vif)
   );

   int n_chk = 0, n_pass = 0;
   int hc, vc, cyc = 0, f_start;
   bit hold_sync, short_on, inj_on;
   int hh[3], vh[3];
   int m_valid, m_badxy, m_baddata, m_fs, m_badfs, m_badidle, m_err, err_step;
   logic [9:0]  o_x, o_y;
   logic [11:0] o_d;
   logic        o_v, o_fs, o_lk, o_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   task automatic clr_mon();
      m_valid = 0; m_badxy = 0; m_baddata = 0; m_fs = 0;
      m_badfs = 0; m_badidle = 0; m_err = 0; err_step = -1;
   endtask

   // One clock: sample outputs (belonging to the input driven 3 steps ago), then drive the next sample.
   task automatic step();
      int ex, ey;
      logic [9:0] exv, eyv, gx, gy;
      logic act;
      @(negedge clk);
      o_x = vif.pix_x; o_y = vif.pix_y; o_d = vif.pix_data;
      o_v = vif.pix_valid; o_fs = vif.frame_start; o_lk = vif.locked; o_err = vif.err;
      ex = hh[2] - HL; ey = vh[2] - VTOP;
      exv = 10'(ex); eyv = 10'(ey);
      if (o_v) begin
         m_valid++;
         if (ex < 0 || ex >= HA || ey < 0 || ey >= VA || o_x != exv || o_y != eyv) m_badxy++;
         if (o_d != {exv[3:0], eyv[3:0], 4'hA}) m_baddata++;
         if (o_fs) begin
            m_fs++;
            if (o_x != 10'd0 || o_y != 10'd0) m_badfs++;
         end
      end else if (o_x != 10'h3FF || o_y != 10'h3FF || o_d != 12'h000 || o_fs) begin
         m_badidle++;
      end
      if (o_err) begin
         m_err++;
         err_step = cyc;
      end
      act = hc >= HL && hc < HL + HA && vc >= VTOP && vc < VTOP + VA;
      gx = 10'(hc - HL); gy = 10'(vc - VTOP);
      vif.hs  = !hold_sync && hc < 2;
      vif.vs  = (!hold_sync && vc < 2) || (inj_on && vc == 5 && (hc == 10 || hc == 11));
      vif.rgb = act ? {gx[3:0], gy[3:0], 4'hA} : 12'h5C3;
      hh[2] = hh[1]; hh[1] = hh[0]; hh[0] = hc;
      vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = vc;
      cyc++;
      if (hc >= ((short_on && vc == 4) ? HT - 2 : HT - 1)) begin
         hc = 0;
         vc = (vc == VT - 1) ? 0 : vc + 1;
      end else begin
         hc++;
      end
   endtask

   task automatic run_frame(input string tag, input int ev, input int ef, input int ee, input logic el);
      int n = 0;
      clr_mon();
      f_start = cyc;
      do begin step(); n++; end while (!(hc == 0 && vc == 0) && n < 400);
      chk({tag, ".bound"}, 32'(n < 400), 32'd1);
      chk({tag, ".valid"}, m_valid, ev);
      chk({tag, ".fs"}, m_fs, ef);
      chk({tag, ".xy"}, m_badxy + m_badfs, 0);
      chk({tag, ".data"}, m_baddata, 0);
      chk({tag, ".idle"}, m_badidle, 0);
      chk({tag, ".err"}, m_err, ee);
      chk({tag, ".locked"}, o_lk, el);
   endtask

   task automatic t1_seq(input string tag);
      int n = 0;
      hc = 0; vc = 0; hold_sync = 0; short_on = 0; inj_on = 0;
      for (int i = 0; i < 3; i++) begin hh[i] = -100; vh[i] = -100; end
      clr_mon();
      repeat (403) step();
      chk({tag, ".locked_early"}, o_lk, 1'b0);
      step();
      chk({tag, ".locked_rise"}, o_lk, 1'b1);
      chk({tag, ".prelock_valid"}, m_valid, 0);
      while (!(hc == 0 && vc == 0) && n < 400) begin step(); n++; end
      chk({tag, ".bound"}, 32'(n < 400), 32'd1);
      chk({tag, ".frame_valid"}, m_valid, 40);
      chk({tag, ".frame_fs"}, m_fs, 1);
      chk({tag, ".frame_xy"}, m_badxy + m_badfs + m_baddata + m_badidle, 0);
      chk({tag, ".frame_err"}, m_err, 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".x"}, vif.pix_x, 10'h3FF);
      chk({tag, ".y"}, vif.pix_y, 10'h3FF);
      chk({tag, ".data"}, vif.pix_data, 12'h000);
      chk({tag, ".valid"}, vif.pix_valid, 1'b0);
      chk({tag, ".fs"}, vif.frame_start, 1'b0);
      chk({tag, ".locked"}, vif.locked, 1'b0);
      chk({tag, ".err"}, vif.err, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      int n, n0;
      rstn = 1'b0;
      vif.hs = 1'b0; vif.vs = 1'b0; vif.rgb = '0;
      hold_sync = 0; short_on = 0; inj_on = 0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      rstn = 1'b1;

      t1_seq("t1");
      run_frame("t2", 40, 1, 0, 1'b1);

      short_on = 1;
      run_frame("t3", 20, 1, 1, 1'b0);
      chk("t3.err_time", err_step, f_start + 4 * HT + (HT - 1) + 3);
      short_on = 0;
      run_frame("t3.hunt", 0, 0, 0, 1'b0);
      run_frame("t3.check", 0, 0, 0, 1'b0);
      run_frame("t3.relock", 40, 1, 0, 1'b1);

      clr_mon();
      n = 0;
      while (!(vc == 4 && hc == 0) && n < 400) begin step(); n++; end
      n0 = cyc - HT;
      hold_sync = 1;
      n = 0;
      do begin step(); n++; end while (!(n >= 1100 && hc == 0 && vc == 0) && n < 3000);
      hold_sync = 0;
      chk("t4.bound", 32'(n < 3000), 32'd1);
      chk("t4.err_count", m_err, 1);
      chk("t4.err_time", err_step, n0 + 1026);
      chk("t4.valid", m_valid, 10);
      chk("t4.locked", o_lk, 1'b0);
      run_frame("t4.hunt", 0, 0, 0, 1'b0);
      run_frame("t4.check", 0, 0, 0, 1'b0);
      run_frame("t4.relock", 40, 1, 0, 1'b1);

      inj_on = 1;
      run_frame("t5", 24, 1, 1, 1'b0);
      chk("t5.err_time", err_step, f_start + 5 * HT + 10 + 3);
      inj_on = 0;
      run_frame("t5.resync", 0, 0, 1, 1'b0);
      chk("t5.resync_time", err_step, f_start + 3);
      run_frame("t5.check", 0, 0, 0, 1'b0);
      run_frame("t5.relock", 40, 1, 0, 1'b1);

      n = 0;
      while (!(vc == 4 && hc == 10) && n < 400) begin step(); n++; end
      chk("t6.pre_valid", o_v, 1'b1);
      #2 rstn = 1'b0;
      #1 chk_reset_outputs("t6.async");
      repeat (3) @(negedge clk);
      vif.hs = 1'b0; vif.vs = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      t1_seq("t6.t1");
      run_frame("t6.t2", 40, 1, 0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
